prienc_capture: RTL and testbench
=================================

Name: prienc_capture

Overview:
- Parametrised successor to the combinational 16-to-4 push-button priority encoder.
- Synchronises and debounces N raw inputs, then detects new presses (rising edges).
- Captures the priority-selected index of each new press into a held code register.
- Handshakes the code to a consumer with valid/ack, plus a one-cycle strobe and a sticky overrun flag.
- Sits between the pb[] inputs and any keypad/entry logic clocked by hz100.

Parameters:
- N, 16, number of input lines (2..32).
- W, $clog2(N), code width; derived, not overridden.
- MSB_FIRST, 1, 1 = highest index wins, 0 = lowest index wins.
- DEBOUNCE, 2, consecutive cycles an input must differ from its debounced value before it is accepted (0 = bypass).

Ports:
- hz100  input  1  system clock.
- reset  input  1  asynchronous reset, active-low (asserted when 0).
- in  input  N  raw button lines, active-high, asynchronous to hz100.
- ack  input  1  consumer acknowledge; meaningful only while valid=1.
- code  output  W  captured index of the winning newly pressed input.
- valid  output  1  code holds an unacknowledged capture.
- strobe  output  1  one-cycle pulse on each capture.
- any  output  1  at least one debounced input is currently high.
- overrun  output  1  sticky: a capture replaced an unacknowledged code.

Behaviour:
- Reset (reset=0, asynchronous): sync flops, debounced state, previous state, counters, code, valid, strobe and overrun all go to 0; any=0.
- Synchroniser: two flops per bit (s1, s2).
- Debounce, DEBOUNCE>0:
  - Each bit has a counter of width $clog2(DEBOUNCE+1).
  - While s2[i] != stable[i], the counter increments; when it reaches DEBOUNCE, stable[i] takes s2[i] and the counter clears.
  - If s2[i] == stable[i], the counter clears, so a bounce restarts the count.
- Debounce, DEBOUNCE=0: stable = s2, no counters.
- Edge detect: prev <= stable every cycle; rise = stable & ~prev (combinational).
- Priority: sel = index of the highest set bit of rise (MSB_FIRST=1) or the lowest (MSB_FIRST=0). Only rising bits compete; inputs already held are ignored.
- Capture: on a clock edge with rise != 0:
  - code <= sel, valid <= 1, strobe <= 1.
  - If valid=1 and ack=0 in that cycle, overrun <= 1.
- Strobe returns to 0 on the next edge unless another capture occurs; back-to-back captures keep strobe high.
- Ack:
  - ack=1 with valid=1 and no rise clears valid and overrun on the next edge; code is held.
  - ack=1 with valid=0 is ignored.
  - ack=1 in the same cycle as a capture: the new capture wins, valid stays 1, overrun is cleared and not set.
- any = |stable (combinational from the register).
- Latency: strobe/valid/code appear DEBOUNCE+3 rising edges after the first edge that samples in[i]=1 (2 sync + DEBOUNCE + 1 capture).
- Release: falling edges produce no capture; code and valid are unaffected.
- Simultaneous rises: exactly one capture; losing bits are dropped and do not re-fire while held.
- Reset mid-operation: everything clears immediately. An input held high through reset release is seen as a new press after DEBOUNCE+3 edges.
- Widths: code is zero-extended to W bits. For N not a power of 2, indices >= N never occur.

Test Plan:
- N=16, DEBOUNCE=2, MSB_FIRST=1; in=0x0020 held -> strobe for exactly 1 cycle on edge 5, code=5, valid=1, any=1, overrun=0.
- Same settings; in=0x8001 rising together -> code=15. Repeat with MSB_FIRST=0 -> code=0. In both cases a single strobe.
- Bounce: in[3] toggles 1,0,1,0 on alternate cycles, then holds 1 -> no strobe during bouncing; one strobe DEBOUNCE+3 edges after the final hold starts; code=3.
- Handshake: capture code=5 and leave ack=0; then press in[9] -> code=9, overrun=1. Pulse ack -> valid=0, overrun=0, code stays 9. Ack again with valid=0 -> no change.
- Ack and press in the same cycle (valid=1, ack=1, rise on bit 2) -> code=2, valid=1, overrun=0.
- Reset: assert reset=0 mid-debounce with in=0x0100 held -> all outputs 0 at once. Release -> strobe, code=8 after DEBOUNCE+3 edges. Also check DEBOUNCE=0 gives latency 3.

Source files
------------

// File: rtl/prienc_capture.sv
// Push-button front end: synchronises and debounces N raw lines, then captures
// the priority-selected index of each new press into a valid/ack handshaked register.
module prienc_capture #(
  parameter int N         = 16,
  parameter int MSB_FIRST = 1,
  parameter int DEBOUNCE  = 2
) (
  input  logic                 hz100,
  input  logic                 reset,
  input  logic [N-1:0]         in,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] code,
  output logic                 valid,
  output logic                 strobe,
  output logic                 any,
  output logic                 overrun
);
  localparam int W = $clog2(N);

  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] stable;
  logic [N-1:0] prev;
  logic [N-1:0] rise;
  logic [W-1:0] sel;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign stable = s2;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE + 1);
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          level;
        // Any sample that agrees with the accepted level restarts the count.
        always_ff @(posedge hz100 or negedge reset) begin
          if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
          end else if (s2[gi] != level) begin
            if (cnt == CW'(DEBOUNCE - 1)) begin
              level <= s2[gi];
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        assign stable[gi] = level;
      end
    end
  endgenerate

  assign rise = stable & ~prev;
  assign any  = |stable;

  // Scan direction makes the last hit the winner for either priority order.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (MSB_FIRST != 0) begin
        if (rise[i]) sel = W'(i);
      end else if (rise[N-1-i]) begin
        sel = W'(N - 1 - i);
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      prev    <= '0;
      code    <= '0;
      valid   <= 1'b0;
      strobe  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev   <= stable;
      strobe <= 1'b0;
      if (|rise) begin
        code   <= sel;
        valid  <= 1'b1;
        strobe <= 1'b1;
        if (valid) overrun <= !ack;
      end else if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prienc_capture.sv
// Scoreboard bench for prienc_capture: three configurations share one stimulus
// stream and are checked against a per-instance behavioural model.
module tb_prienc_capture;
  localparam int NI = 3;

  logic        hz100 = 1'b0;
  logic        reset = 1'b0;
  logic        ack   = 1'b0;
  logic [15:0] in    = '0;

  logic [3:0]    code_o [NI];
  logic [NI-1:0] valid_o, strobe_o, any_o, ovr_o;

  prienc_capture #(.N(16), .MSB_FIRST(1), .DEBOUNCE(2)) dut0 (
    .hz100(hz100), .reset(reset), .in(in), .ack(ack), .code(code_o[0]),
    .valid(valid_o[0]), .strobe(strobe_o[0]), .any(any_o[0]), .overrun(ovr_o[0]));
  prienc_capture #(.N(16), .MSB_FIRST(0), .DEBOUNCE(2)) dut1 (
    .hz100(hz100), .reset(reset), .in(in), .ack(ack), .code(code_o[1]),
    .valid(valid_o[1]), .strobe(strobe_o[1]), .any(any_o[1]), .overrun(ovr_o[1]));
  prienc_capture #(.N(16), .MSB_FIRST(1), .DEBOUNCE(0)) dut2 (
    .hz100(hz100), .reset(reset), .in(in), .ack(ack), .code(code_o[2]),
    .valid(valid_o[2]), .strobe(strobe_o[2]), .any(any_o[2]), .overrun(ovr_o[2]));

  always #5 hz100 = ~hz100;

  function automatic int db_of(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 1);
  endfunction

  // Reference model state
  bit [15:0] m_s1 [NI];
  bit [15:0] m_s2 [NI];
  bit [15:0] m_stable [NI];
  bit [15:0] m_prev [NI];
  int        m_cnt [NI][16];
  int        m_code [NI];
  bit        m_valid [NI];
  bit        m_ovr [NI];

  typedef struct {
    int inst;
    int code;
    bit ovr;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_clear;
    for (int k = 0; k < NI; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_stable[k] = '0; m_prev[k] = '0;
      m_code[k] = 0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
      for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
    end
    exp_q.delete();
  endtask

  // One rising edge: capture/ack decided on pre-edge state, then pipeline advances.
  task automatic model_step;
    bit [15:0] rise;
    int        win;
    exp_t      e;
    for (int k = 0; k < NI; k++) begin
      rise = m_stable[k] & ~m_prev[k];
      if (rise != 0) begin
        win = -1;
        for (int i = 0; i < 16; i++)
          if (rise[i] && (win < 0 || msb_of(k))) win = i;
        if (m_valid[k]) m_ovr[k] = !ack;
        m_code[k]  = win;
        m_valid[k] = 1'b1;
        e.inst = k; e.code = win; e.ovr = m_ovr[k];
        exp_q.push_back(e);
      end else if (ack && m_valid[k]) begin
        m_valid[k] = 1'b0;
        m_ovr[k]   = 1'b0;
      end
      m_prev[k] = m_stable[k];
      if (db_of(k) == 0) begin
        m_stable[k] = m_s1[k];
      end else begin
        for (int i = 0; i < 16; i++) begin
          if (m_s2[k][i] != m_stable[k][i]) begin
            m_cnt[k][i]++;
            if (m_cnt[k][i] == db_of(k)) begin
              m_stable[k][i] = m_s2[k][i];
              m_cnt[k][i] = 0;
            end
          end else begin
            m_cnt[k][i] = 0;
          end
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = in;
    end
  endtask

  initial forever begin
    @(posedge hz100);
    if (reset) model_step();
    else model_clear();
  end

  // Monitor: pops one expected capture per observed strobe, then compares held state.
  initial forever begin
    exp_t e;
    @(posedge hz100);
    #2;
    for (int k = 0; k < NI; k++) begin
      if (strobe_o[k]) begin
        if (exp_q.size() > 0 && exp_q[0].inst == k) begin
          e = exp_q.pop_front();
          check($sformatf("cap_code[%0d]", k), code_o[k], e.code);
          check($sformatf("cap_ovr[%0d]", k), ovr_o[k], e.ovr);
        end else begin
          check($sformatf("unexpected_strobe[%0d]", k), 1, 0);
        end
      end else if (exp_q.size() > 0 && exp_q[0].inst == k) begin
        e = exp_q.pop_front();
        check($sformatf("missed_strobe[%0d]", k), 0, 1);
      end
      check($sformatf("valid[%0d]", k), valid_o[k], m_valid[k]);
      check($sformatf("overrun[%0d]", k), ovr_o[k], m_ovr[k]);
      check($sformatf("any[%0d]", k), any_o[k], |m_stable[k]);
      check($sformatf("code[%0d]", k), code_o[k], m_code[k]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic ack_pulse;
    ack = 1'b1; cyc(1); ack = 1'b0;
  endtask

  // Applies v at the current negedge and counts edges to the first strobe.
  task automatic measure(input bit [15:0] v, input int want_db, input int want_byp, input int wcode);
    int lat [NI];
    for (int k = 0; k < NI; k++) lat[k] = -1;
    in = v;
    for (int e = 1; e <= 12; e++) begin
      @(posedge hz100);
      #1;
      for (int k = 0; k < NI; k++)
        if (strobe_o[k] && lat[k] < 0) lat[k] = e;
    end
    check("latency_db2_msb", lat[0], want_db);
    check("latency_db2_lsb", lat[1], want_db);
    check("latency_db0", lat[2], want_byp);
    check("latency_code", code_o[0], wcode);
    @(negedge hz100);
  endtask

  initial begin
    model_clear();
    cyc(3);
    for (int k = 0; k < NI; k++) begin
      check("reset_code", code_o[k], 0);
      check("reset_valid", valid_o[k], 0);
      check("reset_strobe", strobe_o[k], 0);
      check("reset_any", any_o[k], 0);
      check("reset_overrun", ovr_o[k], 0);
    end
    reset = 1'b1;
    cyc(1);

    measure(16'h0020, 5, 3, 5);
    check("single_any", any_o[0], 1);
    check("single_overrun", ovr_o[0], 0);
    in = '0; cyc(6); ack_pulse(); cyc(2);

    in = 16'h8001; cyc(8);
    check("simul_msb_code", code_o[0], 15);
    check("simul_lsb_code", code_o[1], 0);
    in = '0; cyc(6); ack_pulse(); cyc(2);

    for (int r = 0; r < 2; r++) begin
      in = 16'h0008; cyc(1);
      in = 16'h0000; cyc(1);
    end
    check("bounce_no_valid", valid_o[0], 0);
    in = 16'h0008; cyc(8);
    check("bounce_code", code_o[0], 3);
    ack_pulse(); in = '0; cyc(6);

    in = 16'h0020; cyc(8);
    in = 16'h0220; cyc(8);
    check("hs_code", code_o[0], 9);
    check("hs_overrun", ovr_o[0], 1);
    ack_pulse(); cyc(1);
    check("hs_ack_valid", valid_o[0], 0);
    check("hs_ack_overrun", ovr_o[0], 0);
    check("hs_ack_code", code_o[0], 9);
    ack_pulse(); cyc(1);
    check("hs_idle_ack_code", code_o[0], 9);

    in = 16'h0224; cyc(4);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
    check("ackpress_code", code_o[0], 2);
    check("ackpress_valid", valid_o[0], 1);
    check("ackpress_overrun", ovr_o[0], 0);

    in = '0; cyc(6); ack_pulse(); cyc(2);
    in = 16'h0100; cyc(3);
    reset = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < NI; k++) begin
      check("midreset_code", code_o[k], 0);
      check("midreset_valid", valid_o[k], 0);
      check("midreset_strobe", strobe_o[k], 0);
      check("midreset_any", any_o[k], 0);
    end
    @(negedge hz100);
    reset = 1'b1;
    measure(16'h0100, 5, 3, 8);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) in[$urandom_range(0, 15)] ^= 1'b1;
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        model_clear();
        cyc(1);
        reset = 1'b1;
      end else begin
        cyc(1);
      end
    end
    ack = 1'b0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
